// File: rtl/bus_cycle_ctrl.sv
// 8088-style T1..T4 bus-cycle controller: one single-beat read/write per request,
// wait states driven by bus_ready, and an error response when the wait budget runs out.
module bus_cycle_ctrl #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              ale,
    output logic              rd_wr,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_data_oe,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              bus_ready
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TW   = 3'd4,
        T4   = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_s;
    logic              wr_r, wr_s;
    logic [DATA_W-1:0] wdata_r, wdata_s;

    logic              req_ready_s;
    logic              rsp_valid_s;
    logic [DATA_W-1:0] rsp_rdata_s;
    logic              rsp_err_s;
    logic [ADDR_W-1:0] bus_addr_s;
    logic              ale_s;
    logic              rd_wr_s;
    logic [DATA_W-1:0] bus_data_out_s;
    logic              bus_data_oe_s;

    // Next-state and next-output computation; every output is the registered copy.
    always_comb begin
        state_s        = state_r;
        wait_cnt_s     = wait_cnt_r;
        wr_s           = wr_r;
        wdata_s        = wdata_r;
        req_ready_s    = 1'b0;
        rsp_valid_s    = 1'b0;
        rsp_rdata_s    = rsp_rdata;
        rsp_err_s      = rsp_err;
        bus_addr_s     = bus_addr;
        ale_s          = 1'b0;
        rd_wr_s        = rd_wr;
        bus_data_out_s = bus_data_out;
        bus_data_oe_s  = bus_data_oe;

        case (state_r)
            IDLE: begin
                rd_wr_s       = 1'b0;
                bus_data_oe_s = 1'b0;
                if (req_valid && req_ready) begin
                    state_s     = T1;
                    req_ready_s = 1'b0;
                    ale_s       = 1'b1;
                    bus_addr_s  = req_addr;
                    rd_wr_s     = req_wr;
                    wr_s        = req_wr;
                    wdata_s     = req_wdata;
                end else begin
                    state_s     = IDLE;
                    req_ready_s = 1'b1;
                end
            end
            T1: begin
                state_s    = T2;
                wait_cnt_s = {CNT_W{1'b0}};
                if (wr_r) begin
                    bus_data_out_s = wdata_r;
                    bus_data_oe_s  = 1'b1;
                end else begin
                    bus_data_oe_s  = 1'b0;
                end
            end
            T2: begin
                state_s = T3;
            end
            T3, TW: begin
                // A ready seen on the last permitted sample still wins over the timeout.
                if (bus_ready) begin
                    state_s     = T4;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = wr_r ? {DATA_W{1'b0}} : bus_data_in;
                end else if (wait_cnt_r < MAX_CNT) begin
                    state_s    = TW;
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end else begin
                    state_s     = T4;
                    rsp_valid_s = 1'b1;
                    rsp_err_s   = 1'b1;
                    rsp_rdata_s = {DATA_W{1'b0}};
                end
            end
            T4: begin
                state_s       = IDLE;
                req_ready_s   = 1'b1;
                rd_wr_s       = 1'b0;
                bus_data_oe_s = 1'b0;
            end
            default: begin
                state_s       = IDLE;
                req_ready_s   = 1'b0;
                rd_wr_s       = 1'b0;
                bus_data_oe_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset releases the data pin immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            wait_cnt_r   <= {CNT_W{1'b0}};
            wr_r         <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= {DATA_W{1'b0}};
            rsp_err      <= 1'b0;
            bus_addr     <= {ADDR_W{1'b0}};
            ale          <= 1'b0;
            rd_wr        <= 1'b0;
            bus_data_out <= {DATA_W{1'b0}};
            bus_data_oe  <= 1'b0;
        end else begin
            state_r      <= state_s;
            wait_cnt_r   <= wait_cnt_s;
            wr_r         <= wr_s;
            wdata_r      <= wdata_s;
            req_ready    <= req_ready_s;
            rsp_valid    <= rsp_valid_s;
            rsp_rdata    <= rsp_rdata_s;
            rsp_err      <= rsp_err_s;
            bus_addr     <= bus_addr_s;
            ale          <= ale_s;
            rd_wr        <= rd_wr_s;
            bus_data_out <= bus_data_out_s;
            bus_data_oe  <= bus_data_oe_s;
        end
    end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Parametrised bus-cycle controller for the 8088 processor environment. It turns single-beat read/write requests into 8088-style T1–T4 bus cycles on a multiplexed address/data bus. Ready-driven wait states are inserted, and a bounded wait-state timeout reports an error. It sits between the testbench/agent request side and the DUT-facing bidirectional data and direction pins.

## Interface
- ADDR_W, 20, address width (bus_addr, req_addr)
- DATA_W, 16, data width (all data ports)
- MAX_WAIT, 7, maximum wait states before timeout; 0 = no waits allowed
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_wr  in  1  1 = write (escribir), 0 = read (leer)
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  timeout flag, valid with rsp_valid
- bus_addr  out  ADDR_W  address, driven T1–T4
- ale  out  1  address latch enable, high in T1 only
- rd_wr  out  1  direction pin: 1 = write, 0 = read/idle
- bus_data_out  out  DATA_W  write data to pin driver
- bus_data_oe  out  1  data pin output enable
- bus_data_in  in  DATA_W  data sampled from pin
- bus_ready  in  1  target ready, sampled in T3/TW

## Operation
- States: IDLE, T1, T2, T3, TW, T4.
- IDLE: req_ready=1. On handshake, latch req_wr/req_addr/req_wdata and go to T1. Otherwise stay.
- T1: ale=1, bus_addr=latched addr, rd_wr=latched wr. Go to T2.
- T2: ale=0. For writes, bus_data_out=wdata and bus_data_oe=1 (held through T4). Clear wait counter. Go to T3.
- T3/TW: sample bus_ready.
  - bus_ready=1: go to T4, ok. For reads, capture bus_data_in into rsp_rdata at this edge.
  - bus_ready=0 and wait_cnt<MAX_WAIT: go to TW, wait_cnt+1.
  - bus_ready=0 and wait_cnt==MAX_WAIT: go to T4 with err=1. rsp_rdata=0.
- T4: rsp_valid=1, rsp_err=err. bus_data_oe stays 1 for writes. Go to IDLE. In IDLE, bus_data_oe=0, rd_wr=0, and bus_addr holds its last value.
- wait_cnt width is $clog2(MAX_WAIT+1), minimum 1. It saturates and never wraps.
- req_ready=0 in every state except IDLE. No request queuing. Requests presented during a cycle are ignored until IDLE.
- bus_data_oe=1 is never asserted on a read cycle.

## Timing
- Reset (reset=0, asynchronous): state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, ale=0, rd_wr=0, bus_addr=0, bus_data_out=0, bus_data_oe=0, wait_cnt=0. After release, req_ready=1 from the first rising edge.
- Reset mid-cycle: outputs go to reset values immediately. No rsp_valid is produced for the aborted cycle. The data pin is released the same instant.
- All outputs are registered.
- Handshake at edge E: T1 in cycle E+1, T2 at E+2, T3 at E+3, T4 at E+4 with zero waits. rsp_valid is high during E+4. Next accept is at earliest edge E+5.
- Each wait state adds exactly one cycle. Worst case is E+4+MAX_WAIT with rsp_err=1.
- bus_ready is sampled only in T3/TW. Its value in other states is ignored.
- bus_ready=1 on the same edge that wait_cnt reaches MAX_WAIT counts as success, not error.

## Test plan
- Read, zero waits: req_addr=20'hABCDE, read, bus_ready=1, bus_data_in=16'h1234 -> ale high one cycle at E+1; rsp_valid at E+4 with rsp_rdata=16'h1234, rsp_err=0; bus_data_oe never 1.
- Write, 3 waits: req_addr=20'h00010, wdata=16'hBEEF, bus_ready low for 3 samples -> bus_data_oe=1 and bus_data_out=16'hBEEF from T2 to T4; rd_wr=1; rsp_valid at E+7, rsp_err=0.
- Timeout: MAX_WAIT=7, bus_ready held 0 -> rsp_valid at E+11, rsp_err=1, rsp_rdata=0; ready=1 on the 8th sample instead -> rsp_err=0.
- Back-to-back: req_valid held high with two requests -> accepts at E and E+5; req_ready low E+1..E+4; second ale at E+6.
- Reset mid-operation: assert reset in T2 of a write -> bus_data_oe=0 and rd_wr=0 immediately; no rsp_valid; a fresh read after release completes normally.
- Parameter sweep: ADDR_W=16, DATA_W=8, MAX_WAIT=0, bus_ready=0 in T3 -> rsp_err=1 at E+4; bus_ready=1 -> rsp_err=0.
